// File: rtl/prl_tx_req_arbiter.sv
// rtl/prl_tx_req_arbiter.sv - round-robin arbiter and sequencer for the PRL TX message request port
// Optional WAIT timeout is compiled in when PRL_TX_ARB_TIMEOUT_EN is defined.
module prl_tx_req_arbiter #(
   parameter int          NREQ        = 3,
   parameter logic [15:0] TIMEOUT_CYC = 16'd2000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_en,
   input  logic [7*NREQ-1:0]    req_type,
   input  logic [3*NREQ-1:0]    req_sop_type,
   input  logic [5*NREQ-1:0]    req_info,
   input  logic [36*NREQ-1:0]   req_ex_info,
   output logic [NREQ-1:0]      req_ack,
   output logic [1:0]           req_result,
   output logic                 pe2pl_tx_en,
   output logic [6:0]           pe2pl_tx_type,
   output logic [2:0]           pe2pl_tx_sop_type,
   output logic [4:0]           pe2pl_tx_info,
   output logic [35:0]          pe2pl_tx_ex_info,
   input  logic                 pl2pe_tx_ack,
   input  logic [1:0]           pl2pe_tx_result,
   output logic                 arb_busy,
   output logic [1:0]           arb_grant_id
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
      $error("prl_tx_req_arbiter: NREQ must be in 2..4");
   end
   if (TIMEOUT_CYC == 16'd0) begin : g_bad_timeout
      $error("prl_tx_req_arbiter: TIMEOUT_CYC must be nonzero");
   end

   state_t           state_q, state_d;
   logic             tx_en_q, tx_en_d;
   logic [6:0]       tx_type_q, tx_type_d;
   logic [2:0]       tx_sop_q, tx_sop_d;
   logic [4:0]       tx_info_q, tx_info_d;
   logic [35:0]      tx_ex_info_q, tx_ex_info_d;
   logic [NREQ-1:0]  req_ack_q, req_ack_d;
   logic [1:0]       req_result_q, req_result_d;
   logic             arb_busy_q, arb_busy_d;
   logic [1:0]       arb_grant_id_q, arb_grant_id_d;
   logic [1:0]       last_grant_q, last_grant_d;
`ifdef PRL_TX_ARB_TIMEOUT_EN
   logic [15:0]      cnt_q, cnt_d;
`endif

   logic             pick_vld;
   logic [1:0]       pick_id;
   logic [NREQ-1:0]  grant_onehot;

   // Scan from farthest to nearest so the first set bit after last_grant wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = 2'd0;
      for (int off = NREQ; off >= 1; off--) begin
         if (req_en[(int'(last_grant_q) + off) % NREQ]) begin
            pick_vld = 1'b1;
            pick_id  = 2'((int'(last_grant_q) + off) % NREQ);
         end
      end
   end

   always_comb begin
      grant_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant_onehot[i] = (arb_grant_id_q == 2'(i));
      end
   end

   always_comb begin
      state_d        = state_q;
      tx_en_d        = 1'b0;
      tx_type_d      = tx_type_q;
      tx_sop_d       = tx_sop_q;
      tx_info_d      = tx_info_q;
      tx_ex_info_d   = tx_ex_info_q;
      req_ack_d      = '0;
      req_result_d   = 2'b00;
      arb_busy_d     = arb_busy_q;
      arb_grant_id_d = arb_grant_id_q;
      last_grant_d   = last_grant_q;
`ifdef PRL_TX_ARB_TIMEOUT_EN
      cnt_d          = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               state_d        = S_ISSUE;
               tx_en_d        = 1'b1;
               tx_type_d      = req_type[7*int'(pick_id) +: 7];
               tx_sop_d       = req_sop_type[3*int'(pick_id) +: 3];
               tx_info_d      = req_info[5*int'(pick_id) +: 5];
               tx_ex_info_d   = req_ex_info[36*int'(pick_id) +: 36];
               arb_busy_d     = 1'b1;
               arb_grant_id_d = pick_id;
               last_grant_d   = pick_id;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef PRL_TX_ARB_TIMEOUT_EN
            cnt_d   = 16'd0;
`endif
         end
         S_WAIT: begin
            if (pl2pe_tx_ack) begin
               state_d      = S_DONE;
               req_ack_d    = grant_onehot;
               req_result_d = pl2pe_tx_result;
            end
`ifdef PRL_TX_ARB_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
               state_d      = S_DONE;
               req_ack_d    = grant_onehot;
               req_result_d = 2'b11;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         S_DONE: begin
            state_d      = S_IDLE;
            tx_type_d    = 7'd0;
            tx_sop_d     = 3'd0;
            tx_info_d    = 5'd0;
            tx_ex_info_d = 36'd0;
            arb_busy_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         tx_en_q        <= 1'b0;
         tx_type_q      <= 7'd0;
         tx_sop_q       <= 3'd0;
         tx_info_q      <= 5'd0;
         tx_ex_info_q   <= 36'd0;
         req_ack_q      <= '0;
         req_result_q   <= 2'b00;
         arb_busy_q     <= 1'b0;
         arb_grant_id_q <= 2'd0;
         last_grant_q   <= 2'(NREQ - 1);
`ifdef PRL_TX_ARB_TIMEOUT_EN
         cnt_q          <= 16'd0;
`endif
      end else begin
         state_q        <= state_d;
         tx_en_q        <= tx_en_d;
         tx_type_q      <= tx_type_d;
         tx_sop_q       <= tx_sop_d;
         tx_info_q      <= tx_info_d;
         tx_ex_info_q   <= tx_ex_info_d;
         req_ack_q      <= req_ack_d;
         req_result_q   <= req_result_d;
         arb_busy_q     <= arb_busy_d;
         arb_grant_id_q <= arb_grant_id_d;
         last_grant_q   <= last_grant_d;
`ifdef PRL_TX_ARB_TIMEOUT_EN
         cnt_q          <= cnt_d;
`endif
      end
   end

   assign req_ack           = req_ack_q;
   assign req_result        = req_result_q;
   assign pe2pl_tx_en       = tx_en_q;
   assign pe2pl_tx_type     = tx_type_q;
   assign pe2pl_tx_sop_type = tx_sop_q;
   assign pe2pl_tx_info     = tx_info_q;
   assign pe2pl_tx_ex_info  = tx_ex_info_q;
   assign arb_busy          = arb_busy_q;
   assign arb_grant_id      = arb_grant_id_q;

endmodule

// File: tb/tb_prl_tx_req_arbiter.sv
// tb/tb_prl_tx_req_arbiter.sv - self-checking bench for prl_tx_req_arbiter
// Transaction-timeline reference model plus directed literal checks and random traffic.
module tb_prl_tx_req_arbiter;
   localparam int          NREQ = 3;
   localparam logic [15:0] TO   = 16'd16;
`ifdef PRL_TX_ARB_TIMEOUT_EN
   localparam int          ACK_PCT = 8;
`else
   localparam int          ACK_PCT = 25;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic [NREQ-1:0]     req_en = '0;
   logic [7*NREQ-1:0]   req_type = '0;
   logic [3*NREQ-1:0]   req_sop_type = '0;
   logic [5*NREQ-1:0]   req_info = '0;
   logic [36*NREQ-1:0]  req_ex_info = '0;
   logic [NREQ-1:0]     req_ack;
   logic [1:0]          req_result;
   logic                pe2pl_tx_en;
   logic [6:0]          pe2pl_tx_type;
   logic [2:0]          pe2pl_tx_sop_type;
   logic [4:0]          pe2pl_tx_info;
   logic [35:0]         pe2pl_tx_ex_info;
   logic                pl2pe_tx_ack = 1'b0;
   logic [1:0]          pl2pe_tx_result = 2'b00;
   logic                arb_busy;
   logic [1:0]          arb_grant_id;

   prl_tx_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_en(req_en), .req_type(req_type), .req_sop_type(req_sop_type),
      .req_info(req_info), .req_ex_info(req_ex_info),
      .req_ack(req_ack), .req_result(req_result),
      .pe2pl_tx_en(pe2pl_tx_en), .pe2pl_tx_type(pe2pl_tx_type),
      .pe2pl_tx_sop_type(pe2pl_tx_sop_type), .pe2pl_tx_info(pe2pl_tx_info),
      .pe2pl_tx_ex_info(pe2pl_tx_ex_info),
      .pl2pe_tx_ack(pl2pe_tx_ack), .pl2pe_tx_result(pl2pe_tx_result),
      .arb_busy(arb_busy), .arb_grant_id(arb_grant_id)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a transaction is granted at edge m_tg, may complete at edge >= m_tg+2,
   // shows its ack for one cycle (m_done) and frees the arbiter on the following edge.
   int          cyc = 0;
   int          m_tg = 0;
   bit          m_act = 0;
   bit          m_done = 0;
   logic [1:0]  m_last = 2'(NREQ - 1);
   logic [1:0]  m_gid = 2'd0;
   logic [1:0]  m_res = 2'd0;
   logic [6:0]  m_typ = '0;
   logic [2:0]  m_sop = '0;
   logic [4:0]  m_inf = '0;
   logic [35:0] m_exi = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; m_act = 0; m_done = 0; m_last = 2'(NREQ - 1);
         m_gid = 2'd0; m_res = 2'd0;
      end else begin
         cyc++;
         if (!m_act) begin
            bit found;
            found = 0;
            for (int off = 1; off <= NREQ; off++) begin
               int j;
               j = (int'(m_last) + off) % NREQ;
               if (!found && req_en[j]) begin
                  found = 1; m_act = 1; m_tg = cyc;
                  m_gid = 2'(j); m_last = 2'(j);
                  m_typ = req_type[7*j +: 7];
                  m_sop = req_sop_type[3*j +: 3];
                  m_inf = req_info[5*j +: 5];
                  m_exi = req_ex_info[36*j +: 36];
               end
            end
         end else if (m_done) begin
            m_act = 0; m_done = 0;
         end else if (cyc >= m_tg + 2 && pl2pe_tx_ack) begin
            m_done = 1; m_res = pl2pe_tx_result;
         end
`ifdef PRL_TX_ARB_TIMEOUT_EN
         else if (cyc - m_tg == int'(TO) + 1) begin
            m_done = 1; m_res = 2'b11;
         end
`endif
      end
   end

   always @(negedge clk) begin
      logic [NREQ-1:0] e_ack;
      e_ack = '0;
      if (m_done) e_ack[m_gid] = 1'b1;
      chk("tx_en",    64'(pe2pl_tx_en),       64'(m_act && !m_done && cyc == m_tg));
      chk("busy",     64'(arb_busy),          64'(m_act));
      chk("grant_id", 64'(arb_grant_id),      64'(m_gid));
      chk("req_ack",  64'(req_ack),           64'(e_ack));
      chk("result",   64'(req_result),        64'(m_done ? m_res : 2'b00));
      chk("tx_type",  64'(pe2pl_tx_type),     64'(m_act ? m_typ : 7'd0));
      chk("tx_sop",   64'(pe2pl_tx_sop_type), 64'(m_act ? m_sop : 3'd0));
      chk("tx_info",  64'(pe2pl_tx_info),     64'(m_act ? m_inf : 5'd0));
      chk("tx_exi",   64'(pe2pl_tx_ex_info),  64'(m_act ? m_exi : 36'd0));
   end

   task automatic quiesce();
      req_en = '0;
      pl2pe_tx_ack = 1'b1;
      repeat (6) @(negedge clk);
      pl2pe_tx_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("quiesce_busy", 64'(arb_busy), 64'd0);
   endtask

   initial begin
      int gseq[$];
      #1 rst_n = 1'b0;
      // Round robin from reset with all three requesting continuously.
      req_en = 3'b111;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pl2pe_tx_ack = 1'b1;
      pl2pe_tx_result = 2'b01;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (pe2pl_tx_en) gseq.push_back(int'(arb_grant_id));
         req_en = ~req_ack;
      end
      begin
         int exp_seq[4];
         exp_seq = '{0, 1, 2, 0};
         for (int k = 0; k < 4; k++)
            chk($sformatf("rr_grant%0d", k), 64'(gseq.size() > k ? gseq[k] : 7), 64'(exp_seq[k]));
      end
      quiesce();

      // Single request from requester 1.
      req_type[7*1 +: 7] = 7'h21;
      req_sop_type[3*1 +: 3] = 3'h0;
      req_info[5*1 +: 5] = 5'h13;
      req_en = 3'b010;
      @(negedge clk);
      chk("t1_en",   64'(pe2pl_tx_en),       64'd1);
      chk("t1_type", 64'(pe2pl_tx_type),     64'h21);
      chk("t1_sop",  64'(pe2pl_tx_sop_type), 64'h0);
      chk("t1_info", 64'(pe2pl_tx_info),     64'h13);
      @(negedge clk);
      chk("t1_en_off", 64'(pe2pl_tx_en), 64'd0);
      pl2pe_tx_ack = 1'b1; pl2pe_tx_result = 2'b01;
      @(negedge clk);
      chk("t1_ack", 64'(req_ack),    64'b010);
      chk("t1_res", 64'(req_result), 64'b01);
      pl2pe_tx_ack = 1'b0; req_en = '0;
      @(negedge clk);
      chk("t1_ack_off", 64'(req_ack), 64'd0);
      @(negedge clk);

      // Acks in IDLE and ISSUE are dropped.
      pl2pe_tx_ack = 1'b1; pl2pe_tx_result = 2'b01; req_en = 3'b001;
      @(negedge clk);
      @(negedge clk);
      pl2pe_tx_ack = 1'b0;
      chk("ign_ack_a", 64'(req_ack), 64'd0);
      @(negedge clk);
      chk("ign_ack_b", 64'(req_ack), 64'd0);
      pl2pe_tx_ack = 1'b1; pl2pe_tx_result = 2'b10;
      @(negedge clk);
      chk("ign_real_ack", 64'(req_ack),    64'b001);
      chk("ign_real_res", 64'(req_result), 64'b10);
      pl2pe_tx_ack = 1'b0; req_en = '0;
      repeat (2) @(negedge clk);

      // Descriptor captured at grant, then reset in WAIT.
      req_ex_info[36*2 +: 36] = 36'h123456789;
      req_en = 3'b100;
      @(negedge clk);
      chk("exi_grant", 64'(pe2pl_tx_ex_info), 64'h123456789);
      @(negedge clk);
      req_ex_info[36*2 +: 36] = 36'h0;
      @(negedge clk);
      chk("exi_hold_a", 64'(pe2pl_tx_ex_info), 64'h123456789);
      @(negedge clk);
      chk("exi_hold_b", 64'(pe2pl_tx_ex_info), 64'h123456789);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", 64'(arb_busy),         64'd0);
      chk("rst_exi",  64'(pe2pl_tx_ex_info), 64'd0);
      chk("rst_gid",  64'(arb_grant_id),     64'd0);
      chk("rst_en",   64'(pe2pl_tx_en),      64'd0);
      req_en = 3'b101;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_en",  64'(pe2pl_tx_en),  64'd1);
      chk("post_rst_gid", 64'(arb_grant_id), 64'd0);
      quiesce();

`ifdef PRL_TX_ARB_TIMEOUT_EN
      req_en = 3'b001;
      @(negedge clk);
      chk("to_en", 64'(pe2pl_tx_en), 64'd1);
      repeat (16) @(negedge clk);
      chk("to_early", 64'(req_ack), 64'd0);
      @(negedge clk);
      chk("to_ack", 64'(req_ack),    64'b001);
      chk("to_res", 64'(req_result), 64'b11);
      req_en = '0;
      repeat (2) @(negedge clk);
      req_en = 3'b001;
      @(negedge clk);
      repeat (15) @(negedge clk);
      pl2pe_tx_ack = 1'b1; pl2pe_tx_result = 2'b10;
      @(negedge clk);
      chk("to_race_ack", 64'(req_ack),    64'b001);
      chk("to_race_res", 64'(req_result), 64'b10);
      pl2pe_tx_ack = 1'b0;
      quiesce();
`endif

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (req_en[i] && m_done && m_gid == 2'(i)) begin
               req_en[i] = 1'b0;
            end else if ((!req_en[i] && $urandom_range(0, 3) == 0) || $urandom_range(0, 9) == 0) begin
               req_en[i] = 1'b1;
               req_type[7*i +: 7] = 7'($urandom);
               req_sop_type[3*i +: 3] = 3'($urandom);
               req_info[5*i +: 5] = 5'($urandom);
               req_ex_info[36*i +: 36] = 36'({$urandom, $urandom});
            end
         end
         pl2pe_tx_ack = ($urandom_range(0, 99) < ACK_PCT);
         pl2pe_tx_result = 2'($urandom);
      end
      quiesce();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
